tx_core_param: RTL and testbench

Parametrised UART transmit core: a show-ahead FIFO of configurable width and depth feeding a frame serialiser. The serialiser supports a configurable number of data bits, none/even/odd/mark parity, one or two stop bits, MSB-/LSB-first ordering and line-break generation. It sits between the host write port and the Tx pin, and advances one bit per pulse of the shared baud-rate generator. It adds an overflow flag, a FIFO level, busy/frame-done status and back-to-back framing with no idle gap.

---
 rtl/tx_core_param.sv | 201 ++++++++++++++++++++
 tb/tb_tx_core_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_core_param.sv
// UART transmit core: show-ahead FIFO feeding a baud-paced frame serialiser
// with selectable parity, stop-bit count, bit order and line-break generation.
module tx_core_param #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              n_we_i,
    output logic              p_full_o,
    output logic              p_empty_o,
    output logic [AW:0]       Level_o,
    output logic              p_Overflow_o,
    input  logic              p_BaudSig_i,
    input  logic              p_BigEnd_i,
    input  logic [1:0]        ParityMode_i,
    input  logic              p_TwoStop_i,
    input  logic              p_Break_i,
    output logic              p_Busy_o,
    output logic              p_FrameDone_o,
    output logic              Tx_o
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] fifoMem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [AW:0]       count;
    logic              overflow;
    logic              wrEn;
    logic              pop;
    logic [DATA_W-1:0] headWord;

    assign p_full_o     = (count == (AW + 1)'(DEPTH));
    assign p_empty_o    = (count == '0);
    assign Level_o      = count;
    assign p_Overflow_o = overflow;
    assign wrEn         = !n_we_i && !p_full_o;
    assign headWord     = fifoMem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            fifoMem[wrPtr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({wrEn, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (!n_we_i && p_full_o) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- Serialiser ----------------
    state_t            state;
    logic [DATA_W-1:0] shiftReg;
    logic [CW-1:0]     bitCnt;
    logic              bigEndLat;
    logic [1:0]        parModeLat;
    logic              twoStopLat;
    logic              parBit;
    logic              breakStop;   // current STOP1 is the mark bit after a break
    logic              txReg;
    logic              frameDone;
    logic              lastStop;
    logic              canLaunch;

    function automatic logic parityOf(input logic [DATA_W-1:0] w, input logic [1:0] mode);
        case (mode)
            2'b01:   return ^w;
            2'b10:   return ~^w;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // The IDLE decision is also taken when leaving the final stop bit, so
    // queued frames follow each other without an idle bit.
    always_comb begin
        lastStop  = (state == STOP2) || ((state == STOP1) && (breakStop || !twoStopLat));
        canLaunch = p_BaudSig_i && ((state == IDLE) || lastStop);
        pop       = canLaunch && !p_Break_i && !p_empty_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shiftReg   <= '0;
            bitCnt     <= '0;
            bigEndLat  <= 1'b0;
            parModeLat <= 2'b00;
            twoStopLat <= 1'b0;
            parBit     <= 1'b0;
            breakStop  <= 1'b0;
            txReg      <= 1'b1;
            frameDone  <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (canLaunch) begin
                frameDone <= (state != IDLE) && !breakStop;
                breakStop <= 1'b0;
                if (p_Break_i) begin
                    state <= BREAK;
                    txReg <= 1'b0;
                end else if (!p_empty_o) begin
                    state      <= START;
                    txReg      <= 1'b0;
                    shiftReg   <= headWord;
                    bigEndLat  <= p_BigEnd_i;
                    parModeLat <= ParityMode_i;
                    twoStopLat <= p_TwoStop_i;
                    parBit     <= parityOf(headWord, ParityMode_i);
                end else begin
                    state <= IDLE;
                    txReg <= 1'b1;
                end
            end else if (p_BaudSig_i) begin
                case (state)
                    START, DATA: begin
                        if ((state == DATA) && (bitCnt == CW'(DATA_W))) begin
                            if (parModeLat != 2'b00) begin
                                state <= PARITY;
                                txReg <= parBit;
                            end else begin
                                state <= STOP1;
                                txReg <= 1'b1;
                            end
                        end else begin
                            state  <= DATA;
                            bitCnt <= (state == START) ? CW'(1) : bitCnt + CW'(1);
                            if (bigEndLat) begin
                                txReg    <= shiftReg[DATA_W-1];
                                shiftReg <= {shiftReg[DATA_W-2:0], 1'b0};
                            end else begin
                                txReg    <= shiftReg[0];
                                shiftReg <= {1'b0, shiftReg[DATA_W-1:1]};
                            end
                        end
                    end
                    PARITY: begin
                        state <= STOP1;
                        txReg <= 1'b1;
                    end
                    STOP1: begin
                        state <= STOP2;
                        txReg <= 1'b1;
                    end
                    BREAK: begin
                        if (!p_Break_i) begin
                            state     <= STOP1;
                            txReg     <= 1'b1;
                            breakStop <= 1'b1;
                        end else begin
                            txReg <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        txReg <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign p_Busy_o      = (state != IDLE);
    assign p_FrameDone_o = frameDone;
    assign Tx_o          = txReg;

endmodule

// File: tb/tb_tx_core_param.sv
// Bench for tx_core_param: directed frame table, FIFO/break/reset sequences
// and randomized frames against a bit-stream reference model.
module tb_tx_core_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          n_we_i = 1'b1;
    logic          p_full_o;
    logic          p_empty_o;
    logic [AW:0]   Level_o;
    logic          p_Overflow_o;
    logic          p_BaudSig_i = 1'b0;
    logic          p_BigEnd_i = 1'b0;
    logic [1:0]    ParityMode_i = 2'b00;
    logic          p_TwoStop_i = 1'b0;
    logic          p_Break_i = 1'b0;
    logic          p_Busy_o;
    logic          p_FrameDone_o;
    logic          Tx_o;

    always #5 clk = ~clk;

    tx_core_param #(.DATA_W(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .n_we_i       (n_we_i),
        .p_full_o     (p_full_o),
        .p_empty_o    (p_empty_o),
        .Level_o      (Level_o),
        .p_Overflow_o (p_Overflow_o),
        .p_BaudSig_i  (p_BaudSig_i),
        .p_BigEnd_i   (p_BigEnd_i),
        .ParityMode_i (ParityMode_i),
        .p_TwoStop_i  (p_TwoStop_i),
        .p_Break_i    (p_Break_i),
        .p_Busy_o     (p_Busy_o),
        .p_FrameDone_o(p_FrameDone_o),
        .Tx_o         (Tx_o)
    );

    int vectors = 0;
    int miscompares = 0;
    int fdCount = 0;
    bit expQ[$];

    typedef struct {
        logic [W-1:0] word;
        logic [1:0]   mode;
        bit           big;
        bit           two;
        string        pat;   // expected Tx_o per baud period, left to right
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock; inputs change 1 unit after the edge, outputs sampled there too.
    task automatic step(input bit baud);
        p_BaudSig_i = baud;
        @(posedge clk);
        #1;
        if (p_FrameDone_o) fdCount++;
        p_BaudSig_i = 1'b0;
        n_we_i = 1'b1;
    endtask

    task automatic baudStep();
        step(1'b1);
        repeat ($urandom_range(0, 2)) step(1'b0);
    endtask

    task automatic writeWord(input logic [W-1:0] w);
        n_we_i = 1'b0;
        data_i = w;
        step(1'b0);
    endtask

    // Reference frame: start, data in chosen order, optional parity, stops.
    task automatic pushFrame(input logic [W-1:0] w, input logic [1:0] m, input bit big, input bit two);
        expQ.push_back(1'b0);
        for (int i = 0; i < W; i++) expQ.push_back(big ? w[W-1-i] : w[i]);
        if (m == 2'b01) expQ.push_back(^w);
        else if (m == 2'b10) expQ.push_back(~^w);
        else if (m == 2'b11) expQ.push_back(1'b1);
        expQ.push_back(1'b1);
        if (two) expQ.push_back(1'b1);
    endtask

    task automatic drainStream();
        bit b;
        while (expQ.size() > 0) begin
            b = expQ.pop_front();
            baudStep();
            chk("tx_bit", Tx_o, b);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int fd0;
        int n;
        logic [W-1:0] w;

        vecs[0] = '{8'hA5, 2'b01, 1'b0, 1'b0, "01010010101"};
        vecs[1] = '{8'h01, 2'b10, 1'b1, 1'b1, "000000001011"};
        vecs[2] = '{8'h00, 2'b11, 1'b0, 1'b0, "00000000011"};
        vecs[3] = '{8'hFF, 2'b00, 1'b1, 1'b1, "01111111111"};
        vecs[4] = '{8'h07, 2'b01, 1'b0, 1'b0, "01110000011"};
        vecs[5] = '{8'hC3, 2'b10, 1'b1, 1'b0, "01100001111"};

        // Reset state
        step(1'b0);
        step(1'b0);
        chk("rst_tx", Tx_o, 1);
        chk("rst_busy", p_Busy_o, 0);
        chk("rst_empty", p_empty_o, 1);
        chk("rst_full", p_full_o, 0);
        chk("rst_level", Level_o, 0);
        chk("rst_ovf", p_Overflow_o, 0);
        chk("rst_fd", p_FrameDone_o, 0);
        rst = 1'b1;
        step(1'b0);

        // Directed frame table
        foreach (vecs[k]) begin
            ParityMode_i = vecs[k].mode;
            p_BigEnd_i   = vecs[k].big;
            p_TwoStop_i  = vecs[k].two;
            writeWord(vecs[k].word);
            chk("tbl_level1", Level_o, 1);
            fd0 = fdCount;
            for (int i = 0; i < vecs[k].pat.len(); i++) begin
                baudStep();
                chk("tbl_tx", Tx_o, (vecs[k].pat[i] == "1") ? 1 : 0);
                if (i == 0) chk("tbl_level0", Level_o, 0);
            end
            baudStep();
            chk("tbl_fd", fdCount - fd0, 1);
            chk("tbl_busy", p_Busy_o, 0);
        end

        // Fill to full with baud frozen, then back-to-back drain
        ParityMode_i = 2'b01; p_BigEnd_i = 1'b0; p_TwoStop_i = 1'b0;
        for (int i = 1; i <= 5; i++) writeWord(W'(8'h11 * i));
        chk("full_level", Level_o, 4);
        chk("full_flag", p_full_o, 1);
        chk("full_ovf", p_Overflow_o, 1);
        for (int i = 1; i <= 4; i++) pushFrame(W'(8'h11 * i), 2'b01, 1'b0, 1'b0);
        fd0 = fdCount;
        drainStream();
        baudStep();
        chk("full_fd", fdCount - fd0, 4);
        chk("full_empty", p_empty_o, 1);
        chk("full_ovf_sticky", p_Overflow_o, 1);
        chk("full_busy", p_Busy_o, 0);

        // Break requested mid-frame with a word queued
        ParityMode_i = 2'b00;
        writeWord(8'h5A);
        pushFrame(8'h5A, 2'b00, 1'b0, 1'b0);
        fd0 = fdCount;
        void'(expQ.pop_front());
        baudStep();
        chk("brk_start", Tx_o, 0);
        p_Break_i = 1'b1;
        writeWord(8'h66);
        drainStream();
        for (int i = 0; i < 3; i++) begin
            baudStep();
            chk("brk_low", Tx_o, 0);
            chk("brk_level", Level_o, 1);
        end
        p_Break_i = 1'b0;
        baudStep();
        chk("brk_mark", Tx_o, 1);
        chk("brk_mark_level", Level_o, 1);
        pushFrame(8'h66, 2'b00, 1'b0, 1'b0);
        drainStream();
        chk("brk_pop_level", Level_o, 0);
        baudStep();
        chk("brk_fd", fdCount - fd0, 2);
        chk("brk_idle", p_Busy_o, 0);

        // Settings changed mid-frame only affect the next frame
        ParityMode_i = 2'b01; p_BigEnd_i = 1'b0; p_TwoStop_i = 1'b0;
        writeWord(8'h3C);
        writeWord(8'h96);
        pushFrame(8'h3C, 2'b01, 1'b0, 1'b0);
        pushFrame(8'h96, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            baudStep();
            chk("cfg_tx", Tx_o, expQ.pop_front());
        end
        ParityMode_i = 2'b00; p_BigEnd_i = 1'b1;
        drainStream();
        baudStep();
        chk("cfg_empty", p_empty_o, 1);

        // Asynchronous reset mid-frame discards the FIFO
        ParityMode_i = 2'b01; p_BigEnd_i = 1'b0;
        writeWord(8'hF0); writeWord(8'h0F); writeWord(8'hAA);
        for (int i = 0; i < 4; i++) baudStep();
        chk("ar_level_pre", Level_o, 2);
        #2 rst = 1'b0;
        #1;
        chk("ar_tx", Tx_o, 1);
        chk("ar_empty", p_empty_o, 1);
        chk("ar_level", Level_o, 0);
        chk("ar_busy", p_Busy_o, 0);
        step(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            baudStep();
            chk("ar_no_resume", {p_Busy_o, Tx_o}, 2'b01);
        end

        // Randomized batches against the reference model
        for (int b = 0; b < 25; b++) begin
            ParityMode_i = 2'($urandom_range(0, 3));
            p_BigEnd_i   = 1'($urandom_range(0, 1));
            p_TwoStop_i  = 1'($urandom_range(0, 1));
            n = $urandom_range(1, D);
            for (int i = 0; i < n; i++) begin
                w = W'($urandom);
                writeWord(w);
                pushFrame(w, ParityMode_i, p_BigEnd_i, p_TwoStop_i);
            end
            chk("rnd_level", Level_o, n);
            fd0 = fdCount;
            drainStream();
            baudStep();
            chk("rnd_fd", fdCount - fd0, n);
            chk("rnd_empty", p_empty_o, 1);
            chk("rnd_idle_tx", Tx_o, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
